// File: rtl/pulse_debouncer.sv
// pulse_debouncer: per-channel synchroniser + debounce FSM for raw switch/pulse inputs.
// Each channel produces a clean level plus single-cycle rise/fall strobes on every
// accepted edge; any_rise is the registered OR of the rise strobes.
module pulse_debouncer #(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic            any_rise
);

   // Counter only has to reach DEBOUNCE_CYCLES-1; acceptance happens on the
   // following synced sample, so the counter is reset before it could wrap.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_LOW     = 2'd0;
   localparam logic [1:0] ST_WAIT_HI = 2'd1;
   localparam logic [1:0] ST_HIGH    = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   // Per-channel next-cycle rise strobes, gathered so any_rise stays aligned
   // with rise_pulse (both registered on the same edge).
   logic [N_CH-1:0] rise_next_vec;
   logic            any_rise_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   sync;
         logic [1:0]             state_reg, state_next;
         logic [CNT_W-1:0]       cnt_reg, cnt_next;
         logic                   level_reg, level_next;
         logic                   rise_reg, rise_next;
         logic                   fall_reg, fall_next;

         // Synchroniser chain: bit 0 samples the asynchronous input, the top bit
         // is the only one the FSM is allowed to look at.
         always_ff @(posedge clock) begin
            if (reset) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
            end
         end

         assign sync = sync_reg[SYNC_STAGES-1];

         // Debounce decision: a new level must be seen DEBOUNCE_CYCLES+1 times in a
         // row (one sample to enter WAIT, DEBOUNCE_CYCLES more to accept).
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            level_next = level_reg;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            case (state_reg)
               ST_LOW: begin
                  if (sync) begin
                     state_next = ST_WAIT_HI;
                     cnt_next   = '0;
                  end
               end
               ST_WAIT_HI: begin
                  if (!sync) begin
                     state_next = ST_LOW;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = ST_HIGH;
                     cnt_next   = '0;
                     level_next = 1'b1;
                     rise_next  = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               ST_HIGH: begin
                  if (!sync) begin
                     state_next = ST_WAIT_LO;
                     cnt_next   = '0;
                  end
               end
               ST_WAIT_LO: begin
                  if (sync) begin
                     state_next = ST_HIGH;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = ST_LOW;
                     cnt_next   = '0;
                     level_next = 1'b0;
                     fall_next  = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_next = ST_LOW;
                  cnt_next   = '0;
                  level_next = 1'b0;
               end
            endcase
         end

         // State, counter and registered outputs; reset discards any pending wait.
         always_ff @(posedge clock) begin
            if (reset) begin
               state_reg <= ST_LOW;
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               level_reg <= level_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
            end
         end

         assign rise_next_vec[gi] = rise_next;
         assign level[gi]         = level_reg;
         assign rise_pulse[gi]    = rise_reg;
         assign fall_pulse[gi]    = fall_reg;
      end
   endgenerate

   // Summary strobe for the downstream counter, registered alongside rise_pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         any_rise_reg <= 1'b0;
      end else begin
         any_rise_reg <= |rise_next_vec;
      end
   end

   assign any_rise = any_rise_reg;

endmodule

// File: tb/tb_pulse_debouncer.sv
// tb_pulse_debouncer: directed stimulus, run-length reference model checked every
// cycle, plus hand-computed strobe counts and latencies.
module tb_pulse_debouncer;
   localparam int N_CH = 4;
   localparam int DEB  = 16;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + DEB + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N_CH-1:0] raw_in = '0;
   logic [N_CH-1:0] level, rise_pulse, fall_pulse;
   logic            any_rise;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state: delayed copies of raw_in and run length of disagreement
   logic [N_CH-1:0] m_hist [SYNC];
   logic [N_CH-1:0] m_sync;
   logic [N_CH-1:0] m_level = '0;
   logic [N_CH-1:0] m_rise  = '0;
   logic [N_CH-1:0] m_fall  = '0;
   int              m_run [N_CH];

   // observations of DUT strobes
   int rise_cnt [N_CH];
   int rise_at  [N_CH];
   int fall_cnt [N_CH];
   int fall_at  [N_CH];
   int any_cnt  = 0;
   int any_at   = 0;

   always #5 clock = ~clock;

   pulse_debouncer #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
      .clock      (clock),
      .reset      (reset),
      .raw_in     (raw_in),
      .level      (level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_rise   (any_rise)
   );

   task automatic chk(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Model: the FSM sees raw_in delayed by SYNC edges; a channel flips once the
   // synced value has disagreed with the accepted level for DEB+1 samples in a row.
   initial begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      for (int c = 0; c < N_CH; c++) m_run[c] = 0;
      forever begin
         @(posedge clock);
         cyc++;
         if (reset) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            for (int c = 0; c < N_CH; c++) m_run[c] = 0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
         end else begin
            m_sync = m_hist[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = raw_in;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N_CH; c++) begin
               if (m_sync[c] != m_level[c]) begin
                  m_run[c]++;
                  if (m_run[c] == DEB + 1) begin
                     m_level[c] = m_sync[c];
                     if (m_sync[c]) m_rise[c] = 1'b1;
                     else           m_fall[c] = 1'b1;
                     m_run[c] = 0;
                  end
               end else begin
                  m_run[c] = 0;
               end
            end
         end
      end
   end

   // Compare every cycle, and log strobe counts/times for the directed checks.
   initial begin
      for (int c = 0; c < N_CH; c++) begin
         rise_cnt[c] = 0; rise_at[c] = 0; fall_cnt[c] = 0; fall_at[c] = 0;
      end
      forever begin
         @(negedge clock);
         chk("level", level, m_level);
         chk("rise_pulse", rise_pulse, m_rise);
         chk("fall_pulse", fall_pulse, m_fall);
         chk("any_rise", {3'b000, any_rise}, {3'b000, |m_rise});
         for (int c = 0; c < N_CH; c++) begin
            if (rise_pulse[c] === 1'b1) begin rise_cnt[c]++; rise_at[c] = cyc; end
            if (fall_pulse[c] === 1'b1) begin fall_cnt[c]++; fall_at[c] = cyc; end
         end
         if (any_rise === 1'b1) begin any_cnt++; any_at = cyc; end
      end
   end

   initial begin
      int e0, e1, r, f, ac;
      int rs [N_CH];

      // 1: inputs high while reset is held -> everything stays 0
      reset  = 1'b1;
      raw_in = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("reset_outputs", level | rise_pulse | fall_pulse, 4'h0);
         chk("reset_any_rise", {3'b000, any_rise}, 4'h0);
      end
      raw_in = 4'h0;
      reset  = 1'b0;
      tick(5);

      // 2: channel 0 long press and release
      r = rise_cnt[0]; f = fall_cnt[0];
      raw_in[0] = 1'b1; e0 = cyc;
      tick(40);
      chk("ch0_level_high", {3'b000, level[0]}, 4'h1);
      raw_in[0] = 1'b0; e1 = cyc;
      tick(25);
      chk_int("ch0_rise_count", rise_cnt[0] - r, 1);
      chk_int("ch0_rise_latency", rise_at[0] - e0, LAT);
      chk_int("ch0_fall_count", fall_cnt[0] - f, 1);
      chk_int("ch0_fall_latency", fall_at[0] - e1, LAT);
      chk("ch0_level_low", {3'b000, level[0]}, 4'h0);

      // 3: channel 1 threshold, 16 synced cycles rejected, 17 accepted
      r = rise_cnt[1]; f = fall_cnt[1];
      raw_in[1] = 1'b1;
      tick(16);
      raw_in[1] = 1'b0;
      tick(25);
      chk_int("ch1_16cyc_rise_count", rise_cnt[1] - r, 0);
      chk("ch1_16cyc_level", {3'b000, level[1]}, 4'h0);
      raw_in[1] = 1'b1; e0 = cyc;
      tick(17);
      raw_in[1] = 1'b0; e1 = cyc;
      tick(40);
      chk_int("ch1_17cyc_rise_count", rise_cnt[1] - r, 1);
      chk_int("ch1_17cyc_rise_latency", rise_at[1] - e0, LAT);
      chk_int("ch1_17cyc_fall_count", fall_cnt[1] - f, 1);
      chk_int("ch1_17cyc_fall_latency", fall_at[1] - e1, LAT);

      // 4: channel 2 bouncing every 3 cycles then held high
      r = rise_cnt[2]; f = fall_cnt[2];
      for (int i = 0; i < 30; i++) begin
         raw_in[2] = ((i / 3) % 2 == 0);
         tick(1);
      end
      raw_in[2] = 1'b1; e0 = cyc;
      tick(25);
      chk_int("ch2_bounce_rise_count", rise_cnt[2] - r, 1);
      chk_int("ch2_bounce_rise_latency", rise_at[2] - e0, LAT);
      chk_int("ch2_bounce_fall_count", fall_cnt[2] - f, 0);
      chk("ch2_level", {3'b000, level[2]}, 4'h1);
      raw_in[2] = 1'b0;
      tick(25);

      // 5: all channels rise together
      for (int c = 0; c < N_CH; c++) rs[c] = rise_cnt[c];
      ac = any_cnt;
      raw_in = 4'hF; e0 = cyc;
      tick(25);
      for (int c = 0; c < N_CH; c++) begin
         chk_int($sformatf("all_rise_count_ch%0d", c), rise_cnt[c] - rs[c], 1);
         chk_int($sformatf("all_rise_latency_ch%0d", c), rise_at[c] - e0, LAT);
      end
      chk_int("any_rise_count", any_cnt - ac, 1);
      chk_int("any_rise_latency", any_at - e0, LAT);
      chk("all_level", level, 4'hF);
      raw_in = 4'h0;
      tick(25);

      // 6: reset in the middle of channel 3's wait discards the pending press
      r = rise_cnt[3];
      raw_in[3] = 1'b1;
      tick(13);
      reset = 1'b1;
      tick(2);
      chk_int("ch3_no_rise_before_release", rise_cnt[3] - r, 0);
      reset = 1'b0; e0 = cyc;
      tick(25);
      chk_int("ch3_rise_count", rise_cnt[3] - r, 1);
      chk_int("ch3_rise_latency", rise_at[3] - e0, LAT);
      raw_in[3] = 1'b0;
      tick(25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
